// File: rtl/eu_tx_buf.sv
// Transmit buffer for an execution unit: queues ALU result writes in a FIFO and
// sends them one at a time on the tx channel, backing off after each reject.
module eu_tx_buf #(
  parameter int DATA_WIDTH     = 16,
  parameter int ADDR_WIDTH     = 8,
  parameter int DEPTH          = 4,
  parameter int BACKOFF_CYCLES = 2,
  parameter int CNT_WIDTH      = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     alu_wr_valid,
  input  logic [ADDR_WIDTH-1:0]    alu_wr_addr,
  input  logic [DATA_WIDTH-1:0]    alu_wr_data,
  output logic                     alu_wr_ready,
  output logic                     out_valid,
  output logic [ADDR_WIDTH-1:0]    out_addr,
  output logic [DATA_WIDTH-1:0]    out_data,
  input  logic                     out_success,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic [CNT_WIDTH-1:0]     reject_cnt
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int BO_LOAD = (BACKOFF_CYCLES > 0) ? BACKOFF_CYCLES - 1 : 0;
  localparam int BO_W    = (BO_LOAD > 0) ? $clog2(BO_LOAD + 1) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND    = 2'd1,
    BACKOFF = 2'd2
  } state_t;

  logic [ADDR_WIDTH-1:0] addr_mem [DEPTH];
  logic [DATA_WIDTH-1:0] data_mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic [PTR_W:0]   count_next;
  logic             full;
  logic             push;
  logic             pop;

  state_t           state_q;
  state_t           state_d;
  logic [BO_W-1:0]  bo_ctr;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  // Ready depends only on fullness, so a full buffer refuses writes even while popping.
  assign full         = (count == (PTR_W + 1)'(DEPTH));
  assign alu_wr_ready = ~full;
  assign push         = alu_wr_valid & alu_wr_ready;
  assign pop          = out_valid & out_success;
  assign occupancy    = count;

  assign out_addr = addr_mem[rd_ptr];
  assign out_data = data_mem[rd_ptr];

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + (PTR_W + 1)'(1);
      2'b01:   count_next = count - (PTR_W + 1)'(1);
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr] <= alu_wr_addr;
      data_mem[wr_ptr] <= alu_wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_next;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (count != '0) state_d = SEND;
      end
      SEND: begin
        if (out_success) begin
          state_d = (count_next != '0) ? SEND : IDLE;
        end else if (BACKOFF_CYCLES > 0) begin
          state_d = BACKOFF;
        end
      end
      BACKOFF: begin
        if (bo_ctr == '0) state_d = SEND;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    out_valid = (state_q == SEND);
  end

  // The head entry stays put during backoff, so the retry resends identical addr/data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bo_ctr <= '0;
    end else if (state_q == SEND && !out_success && BACKOFF_CYCLES > 0) begin
      bo_ctr <= BO_W'(BO_LOAD);
    end else if (state_q == BACKOFF && bo_ctr != '0) begin
      bo_ctr <= bo_ctr - BO_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      reject_cnt <= '0;
    end else if (out_valid && !out_success) begin
      reject_cnt <= sat_inc(reject_cnt);
    end
  end

endmodule

// File: tb/tb_eu_tx_buf.sv
// Bench for eu_tx_buf: two instances (backoff 2 and backoff 0) driven with the same
// stimulus, each checked every cycle against a queue-based model plus literal checks.
module tb_eu_tx_buf;

  localparam int DEPTH = 4;

  logic        clk;
  logic        reset_n;
  logic        alu_wr_valid;
  logic [7:0]  alu_wr_addr;
  logic [15:0] alu_wr_data;
  logic        out_success;

  int n_chk;
  int n_fail;
  int proto_err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : gi
    localparam int BO = (g == 0) ? 2 : 0;

    logic        rdy;
    logic        ov;
    logic [7:0]  oa;
    logic [15:0] od;
    logic [2:0]  occ;
    logic [3:0]  rc;

    eu_tx_buf #(
      .DATA_WIDTH(16), .ADDR_WIDTH(8), .DEPTH(DEPTH),
      .BACKOFF_CYCLES(BO), .CNT_WIDTH(4)
    ) u_dut (
      .clk(clk), .reset_n(reset_n),
      .alu_wr_valid(alu_wr_valid), .alu_wr_addr(alu_wr_addr),
      .alu_wr_data(alu_wr_data), .alu_wr_ready(rdy),
      .out_valid(ov), .out_addr(oa), .out_data(od),
      .out_success(out_success), .occupancy(occ), .reject_cnt(rc)
    );

    // Model: packet queue, reject count, and a forced-idle countdown after each reject.
    logic [23:0] q[$];
    int  hold;
    int  mrej;
    bit  mv;
    bit  had;
    bit  was_v;

    always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        q.delete();
        hold = 0;
        mrej = 0;
        mv   = 1'b0;
      end else begin
        had   = (q.size() > 0);
        was_v = mv;
        if (alu_wr_valid && q.size() >= DEPTH) begin
          proto_err++;
          $display("note: ALU protocol error, write while alu_wr_ready=0 ignored (inst %0d)", g);
        end
        if (was_v && out_success) void'(q.pop_front());
        if (alu_wr_valid && (had ? q.size() + ((was_v && out_success) ? 1 : 0) : 0) < DEPTH)
          q.push_back({alu_wr_addr, alu_wr_data});
        if (was_v && !out_success) begin
          if (mrej < 15) mrej++;
          hold = BO;
        end else if (hold > 0) begin
          hold--;
        end
        mv = (hold == 0) && (was_v ? (q.size() > 0) : had);
      end
    end

    always @(negedge clk) begin
      chk($sformatf("g%0d.ready", g), rdy, (q.size() < DEPTH));
      chk($sformatf("g%0d.occupancy", g), occ, q.size());
      chk($sformatf("g%0d.out_valid", g), ov, mv);
      chk($sformatf("g%0d.reject_cnt", g), rc, mrej);
      if (mv && q.size() > 0) begin
        chk($sformatf("g%0d.out_addr", g), oa, q[0][23:16]);
        chk($sformatf("g%0d.out_data", g), od, q[0][15:0]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    alu_wr_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
  endtask

  task automatic drain();
    alu_wr_valid = 1'b0;
    out_success  = 1'b1;
    repeat (12) tick();
  endtask

  logic [3:0] pat;

  initial begin
    n_chk = 0; n_fail = 0; proto_err = 0;
    reset_n = 1'b1;
    alu_wr_valid = 1'b0; alu_wr_addr = '0; alu_wr_data = '0; out_success = 1'b0;
    #1 reset_n = 1'b0;
    #2;
    for (int i = 0; i < 2; i++) begin
      chk("rst.out_valid", (i == 0) ? gi[0].ov : gi[1].ov, 0);
      chk("rst.ready", (i == 0) ? gi[0].rdy : gi[1].rdy, 1);
      chk("rst.occupancy", (i == 0) ? gi[0].occ : gi[1].occ, 0);
      chk("rst.reject_cnt", (i == 0) ? gi[0].rc : gi[1].rc, 0);
    end
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;

    // Single packet
    out_success = 1'b1;
    alu_wr_valid = 1'b1; alu_wr_addr = 8'h12; alu_wr_data = 16'hBEEF;
    tick();
    alu_wr_valid = 1'b0;
    @(negedge clk);
    chk("single.valid_e1", gi[0].ov, 0);
    chk("single.occ_e1", gi[0].occ, 1);
    tick();
    @(negedge clk);
    chk("single.valid_e2", gi[0].ov, 1);
    chk("single.addr", gi[0].oa, 8'h12);
    chk("single.data", gi[0].od, 16'hBEEF);
    chk("single.valid_e2_bo0", gi[1].ov, 1);
    tick();
    @(negedge clk);
    chk("single.valid_e3", gi[0].ov, 0);
    chk("single.occ_e3", gi[0].occ, 0);
    drain();

    // Fill and stream
    do_reset();
    out_success = 1'b0;
    for (int i = 0; i < 5; i++) begin
      alu_wr_valid = 1'b1;
      alu_wr_addr  = 8'h40 + 8'(i);
      alu_wr_data  = 16'h1000 + 16'(i);
      if (i == 4) begin
        @(negedge clk);
        chk("fill.ready_full", gi[1].rdy, 0);
        chk("fill.occ_full", gi[1].occ, 4);
      end
      tick();
    end
    alu_wr_valid = 1'b0;
    out_success  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("stream.valid", gi[1].ov, 1);
      chk("stream.addr", gi[1].oa, 8'h40 + 8'(k));
      chk("stream.data", gi[1].od, 16'h1000 + 16'(k));
      tick();
    end
    @(negedge clk);
    chk("stream.valid_end", gi[1].ov, 0);
    chk("stream.occ_end", gi[1].occ, 0);
    drain();

    // Backoff
    do_reset();
    out_success = 1'b0;
    alu_wr_valid = 1'b1; alu_wr_addr = 8'h34; alu_wr_data = 16'h1234;
    tick();
    alu_wr_valid = 1'b0;
    tick();
    @(negedge clk);
    pat[3] = gi[0].ov;
    chk("backoff.addr1", gi[0].oa, 8'h34);
    chk("backoff.data1", gi[0].od, 16'h1234);
    tick();
    out_success = 1'b1;
    @(negedge clk);
    pat[2] = gi[0].ov;
    tick();
    @(negedge clk);
    pat[1] = gi[0].ov;
    tick();
    @(negedge clk);
    pat[0] = gi[0].ov;
    chk("backoff.pattern", pat, 4'b1001);
    chk("backoff.addr2", gi[0].oa, 8'h34);
    chk("backoff.data2", gi[0].od, 16'h1234);
    chk("backoff.reject_cnt", gi[0].rc, 1);
    tick();
    @(negedge clk);
    chk("backoff.valid_end", gi[0].ov, 0);
    chk("backoff.occ_end", gi[0].occ, 0);
    drain();

    // Simultaneous push and pop
    do_reset();
    out_success = 1'b0;
    alu_wr_valid = 1'b1; alu_wr_addr = 8'h51; alu_wr_data = 16'hA001;
    tick();
    alu_wr_addr = 8'h52; alu_wr_data = 16'hB002;
    tick();
    alu_wr_addr = 8'h53; alu_wr_data = 16'hC003;
    out_success = 1'b1;
    @(negedge clk);
    chk("pushpop.occ_before", gi[1].occ, 2);
    chk("pushpop.head_a", gi[1].oa, 8'h51);
    tick();
    alu_wr_valid = 1'b0;
    @(negedge clk);
    chk("pushpop.occ_same", gi[1].occ, 2);
    chk("pushpop.head_b", gi[1].oa, 8'h52);
    tick();
    @(negedge clk);
    chk("pushpop.head_c", gi[1].oa, 8'h53);
    chk("pushpop.data_c", gi[1].od, 16'hC003);
    tick();
    @(negedge clk);
    chk("pushpop.valid_end", gi[1].ov, 0);
    drain();

    // Reject counter saturation
    do_reset();
    out_success = 1'b0;
    alu_wr_valid = 1'b1; alu_wr_addr = 8'h77; alu_wr_data = 16'h7777;
    tick();
    alu_wr_valid = 1'b0;
    repeat (22) tick();
    @(negedge clk);
    chk("sat.reject_cnt", gi[1].rc, 15);
    drain();

    // Asynchronous reset mid-operation
    do_reset();
    out_success = 1'b0;
    for (int i = 0; i < 3; i++) begin
      alu_wr_valid = 1'b1;
      alu_wr_addr  = 8'h60 + 8'(i);
      alu_wr_data  = 16'h6000 + 16'(i);
      tick();
    end
    alu_wr_valid = 1'b0;
    tick();
    @(negedge clk);
    chk("midrst.valid_before", gi[1].ov, 1);
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    chk("midrst.valid0", gi[0].ov, 0);
    chk("midrst.valid1", gi[1].ov, 0);
    chk("midrst.occ0", gi[0].occ, 0);
    chk("midrst.occ1", gi[1].occ, 0);
    chk("midrst.ready1", gi[1].rdy, 1);
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    out_success = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("midrst.idle0", gi[0].ov, 0);
      chk("midrst.idle1", gi[1].ov, 0);
      tick();
    end

    // Randomized traffic
    for (int c = 0; c < 500; c++) begin
      alu_wr_valid = ($urandom_range(0, 99) < 55);
      alu_wr_addr  = 8'($urandom);
      alu_wr_data  = 16'($urandom);
      out_success  = ($urandom_range(0, 99) < 50);
      tick();
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/eu_tx_buf.md
Name: eu_tx_buf

Overview:
Transmit-side buffer of an execution unit. It queues ALU result writes (destination address plus data) in a FIFO and drives them onto the interconnect tx channel one packet at a time, using the receiving cache's success handshake. After a rejected packet it waits a programmable backoff before retrying, so it does not keep hammering a full receiver. At the parent, out_valid, out_addr and out_data pack into type_icon_tx_channel, and out_success connects to the receiver's success output.

Parameters:
DATA_WIDTH, 16, payload width of each packet
ADDR_WIDTH, 8, destination exec-unit cache address width
DEPTH, 4, FIFO entries; power of 2, at least 2
BACKOFF_CYCLES, 2, idle cycles after a reject before resending; 0 means retry on the next cycle
CNT_WIDTH, 8, width of the saturating reject counter

Ports:
clk  in  1  single clock domain; all state updates on the rising edge
reset_n  in  1  asynchronous, active-low reset
alu_wr_valid  in  1  ALU presents a result
alu_wr_addr  in  ADDR_WIDTH  destination address of the result
alu_wr_data  in  DATA_WIDTH  result data
alu_wr_ready  out  1  equals ~full; a write is accepted when valid & ready
out_valid  out  1  packet valid on the interconnect
out_addr  out  ADDR_WIDTH  address of the FIFO head entry
out_data  out  DATA_WIDTH  data of the FIFO head entry
out_success  in  1  receiver accepts the packet this cycle; sampled only while out_valid=1
occupancy  out  $clog2(DEPTH)+1  number of entries currently held
reject_cnt  out  CNT_WIDTH  saturating count of cycles with out_valid & ~out_success

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - Pointers and occupancy go to 0; the FSM goes to IDLE.
  - out_valid=0, reject_cnt=0, alu_wr_ready=1.
  - out_addr/out_data are don't-care while out_valid=0. The bench must not check them then.
  - Reset asserted mid-transfer discards all entries. No packet is emitted after reset is released until a new write arrives.
- FIFO:
  - Write pointer and read pointer each wrap modulo DEPTH.
  - Push = alu_wr_valid & alu_wr_ready.
  - Pop = out_valid & out_success.
  - Push and pop in the same cycle leave occupancy unchanged.
  - When full, alu_wr_ready=0 even if a pop occurs that cycle; there is no write-through-when-full.
  - Writes with alu_wr_ready=0 are ignored, and the bench must flag them as an ALU protocol error.
- The head entry drives out_addr/out_data combinationally from storage. The head must be stable while out_valid=1 and not yet popped.
- FSM states: IDLE, SEND, BACKOFF. out_valid=1 only in SEND.
  - IDLE: if occupancy>0, go to SEND. A push into an empty buffer therefore gives out_valid=1 one cycle after the accepting edge (minimum latency 1 cycle).
  - SEND, out_success=1: pop. If the post-pop occupancy is >0 (including the case of a simultaneous push), stay in SEND and present the next head back-to-back. Otherwise go to IDLE.
  - SEND, out_success=0: increment reject_cnt, saturating at all-ones.
    - If BACKOFF_CYCLES=0, stay in SEND.
    - Otherwise load bo_ctr=BACKOFF_CYCLES-1 and go to BACKOFF.
  - BACKOFF: out_valid=0. If bo_ctr==0, go to SEND; otherwise decrement bo_ctr. The same head is retried with the same addr/data. Pushes are still accepted during BACKOFF.
- out_success while out_valid=0 is ignored.
- Ordering is strictly FIFO. There is no reordering or dropping except at reset.

Test Plan:
- Single packet: push addr=0x12 data=0xBEEF into an empty buffer, out_success tied to 1. Required: out_valid high exactly 1 cycle later with 0x12/0xBEEF; occupancy sequence 1→0; out_valid low afterwards.
- Fill and stream: out_success=0 and BACKOFF_CYCLES=0 while 5 pushes are attempted. Required: the 5th is refused (alu_wr_ready=0, occupancy=4). Then set out_success=1: 4 packets emerge on consecutive cycles in push order.
- Backoff: BACKOFF_CYCLES=2, single entry, out_success=0 on the first attempt then 1. Required: out_valid pattern 1,0,0,1; same addr/data both times; reject_cnt=1.
- Simultaneous push/pop: occupancy=2, SEND, out_success=1, with a push the same cycle. Required: occupancy stays 2; the next head is entry 2; the pushed entry is delivered third.
- Saturation: CNT_WIDTH=4, BACKOFF_CYCLES=0, out_success=0 for 20 cycles. Required: reject_cnt stops at 15.
- Reset mid-operation: 3 entries queued and in SEND, then assert reset_n=0 asynchronously between edges. Required: out_valid=0 and occupancy=0 immediately. After release, out_valid stays 0 until a new push.
